serial_to_parallel: RTL and testbench

Receive-side deserializer and Hamming(7,4) decoder for the serial codeword link. Samples one bit per clock from the single-wire serial stream, which arrives MSB (hm[6]) first in 7-bit frames with no gaps. Reassembles each 7-bit codeword, computes its syndrome, and presents the codeword, the 4 data bits and the error status with a one-cycle valid strobe. Sits directly after the link, feeding the block's data consumer.

---
 rtl/serial_to_parallel_pkg.sv | 34 +++
 rtl/serial_to_parallel_decode.sv | 44 ++++
 rtl/serial_to_parallel.sv | 126 ++++++++++++
 tb/tb_serial_to_parallel.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_to_parallel_pkg.sv
// serial_to_parallel_pkg
// Shared definitions for the serial Hamming(7,4) receive path:
//   - bit positions of the codeword fields inside hm[6:0]
//   - frame length
//   - receiver FSM state type
//   - syndrome helper
package serial_to_parallel_pkg;

  // Codeword layout: hm[6]..hm[0] = positions 1..7 = p1 p2 d1 p4 d2 d3 d4
  localparam int unsigned P1 = 6;
  localparam int unsigned P2 = 5;
  localparam int unsigned D1 = 4;
  localparam int unsigned P4 = 3;
  localparam int unsigned D2 = 2;
  localparam int unsigned D3 = 1;
  localparam int unsigned D4 = 0;

  localparam int unsigned FRAME_LEN = 7;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } rx_state_t;

  // Returns {s4, s2, s1}; a nonzero value is the 1-based erroneous position.
  function automatic logic [2:0] hamming74_syndrome(input logic [6:0] hm);
    logic s1, s2, s4;
    s1 = hm[P1] ^ hm[D1] ^ hm[D2] ^ hm[D4];
    s2 = hm[P2] ^ hm[D1] ^ hm[D3] ^ hm[D4];
    s4 = hm[P4] ^ hm[D2] ^ hm[D3] ^ hm[D4];
    return {s4, s2, s1};
  endfunction

endpackage

// File: rtl/serial_to_parallel_decode.sv
// hamming74_decode
// Combinational Hamming(7,4) decoder.
// Optional feature macro: HAMMING_CORRECT_EN
//   defined   - the bit at the syndrome position is inverted before data
//               extraction (single-bit correction)
//   undefined - data is extracted from the raw codeword
// Ports:
//   hm       in  7 - codeword, hm[6] = position 1
//   syndrome out 3 - {s4, s2, s1}
//   err      out 1 - syndrome nonzero
//   data     out 4 - {d1, d2, d3, d4}
module hamming74_decode
  import serial_to_parallel_pkg::*;
(
  input  logic [6:0] hm,
  output logic [2:0] syndrome,
  output logic       err,
  output logic [3:0] data
);

  logic [6:0] cw;

  assign syndrome = hamming74_syndrome(hm);
  assign err      = |syndrome;

`ifdef HAMMING_CORRECT_EN
  logic [2:0] flip_idx;

  // Position p lives at hm[7-p]; syndrome 0 means nothing to flip.
  assign flip_idx = 3'(FRAME_LEN) - syndrome;

  always_comb begin
    cw = hm;
    if (err) begin
      cw[flip_idx] = ~hm[flip_idx];
    end
  end
`else
  assign cw = hm;
`endif

  assign data = {cw[D1], cw[D2], cw[D3], cw[D4]};

endmodule

// File: rtl/serial_to_parallel.sv
// serial_to_parallel
// Receive-side deserializer + Hamming(7,4) decoder for the serial codeword
// link. Frames are 7 bits, hm[6] first, back to back.
// Optional feature macro: HAMMING_CORRECT_EN (single-bit correction of
// data_out; hm_in is always the raw codeword).
// Parameters:
//   ERR_CNT_W - width of the saturating error-frame counter
// Ports:
//   clk      in  1         - clock, rising edge
//   rst_n    in  1         - asynchronous active-low reset
//   chuan    in  1         - serial bit stream
//   align    in  1         - frame sync: chuan at this edge is hm[6]
//   hm_in    out 7         - last received codeword (uncorrected)
//   data_out out 4         - decoded {d1,d2,d3,d4}
//   syndrome out 3         - {s4,s2,s1} of last frame
//   err      out 1         - last frame had nonzero syndrome
//   valid    out 1         - one-cycle pulse when outputs update
//   err_cnt  out ERR_CNT_W - saturating count of erroneous frames
module serial_to_parallel
  import serial_to_parallel_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 chuan,
  input  logic                 align,
  output logic [6:0]           hm_in,
  output logic [3:0]           data_out,
  output logic [2:0]           syndrome,
  output logic                 err,
  output logic                 valid,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [2:0] LAST_BIT = 3'(FRAME_LEN - 1);

  rx_state_t  state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  // Only the six bits preceding the current one are stored; the seventh
  // bit of a frame is taken straight from chuan at the completing edge.
  logic [5:0] shift, shift_nxt;
  logic       frame_done;

  logic [6:0] codeword;
  logic [2:0] dec_syndrome;
  logic       dec_err;
  logic [3:0] dec_data;

  assign codeword = {shift, chuan};

  hamming74_decode u_decode (
    .hm       (codeword),
    .syndrome (dec_syndrome),
    .err      (dec_err),
    .data     (dec_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SYNC;
      cnt   <= '0;
      shift <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      shift <= shift_nxt;
    end
  end

  // align overrides everything, including a frame completing on the same edge.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    shift_nxt  = shift;
    frame_done = 1'b0;
    if (align) begin
      state_nxt = RUN;
      cnt_nxt   = 3'd1;
      shift_nxt = {5'b0, chuan};
    end else begin
      case (state)
        SYNC: begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
        RUN: begin
          shift_nxt = {shift[4:0], chuan};
          if (cnt == LAST_BIT) begin
            cnt_nxt    = '0;
            frame_done = 1'b1;
          end else begin
            cnt_nxt = cnt + 3'd1;
          end
        end
        default: begin
          state_nxt = SYNC;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hm_in    <= '0;
      data_out <= '0;
      syndrome <= '0;
      err      <= 1'b0;
      valid    <= 1'b0;
      err_cnt  <= '0;
    end else begin
      valid <= frame_done;
      if (frame_done) begin
        hm_in    <= codeword;
        data_out <= dec_data;
        syndrome <= dec_syndrome;
        err      <= dec_err;
        if (dec_err && (err_cnt != '1)) begin
          err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_to_parallel.sv
// tb_serial_to_parallel
// Self-checking bench for serial_to_parallel. Directed and random frames are
// driven serially; a frame-level reference model (bit queue, position-sum
// syndrome) predicts every output after every edge.
// Honours HAMMING_CORRECT_EN in its model the same way the design does.
module tb_serial_to_parallel;

  localparam int unsigned CW = 8;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          chuan;
  logic          align;
  logic [6:0]    hm_in;
  logic [3:0]    data_out;
  logic [2:0]    syndrome;
  logic          err;
  logic          valid;
  logic [CW-1:0] err_cnt;

  serial_to_parallel #(.ERR_CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .chuan    (chuan),
    .align    (align),
    .hm_in    (hm_in),
    .data_out (data_out),
    .syndrome (syndrome),
    .err      (err),
    .valid    (valid),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model state
  bit       mq[$];
  bit       msync;
  bit [6:0] e_hm;
  bit [3:0] e_data;
  bit [2:0] e_syn;
  bit       e_err;
  bit       e_valid;
  int       e_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_all();
    check("hm_in",    32'(hm_in),    32'(e_hm));
    check("data_out", 32'(data_out), 32'(e_data));
    check("syndrome", 32'(syndrome), 32'(e_syn));
    check("err",      32'(err),      32'(e_err));
    check("valid",    32'(valid),    32'(e_valid));
    check("err_cnt",  32'(err_cnt),  32'(e_cnt));
  endtask

  task automatic model_reset();
    mq.delete();
    msync   = 1'b1;
    e_hm    = '0;
    e_data  = '0;
    e_syn   = '0;
    e_err   = 1'b0;
    e_valid = 1'b0;
    e_cnt   = 0;
  endtask

  // One clock edge of the receiver, described at frame level.
  task automatic model_edge(input bit b, input bit a);
    bit pos[1:7];
    int syn;
    e_valid = 1'b0;
    if (a) begin
      mq.delete();
      mq.push_back(b);
      msync = 1'b0;
    end else if (msync) begin
      msync = 1'b0;
    end else begin
      mq.push_back(b);
      if (mq.size() == 7) begin
        syn = 0;
        for (int p = 1; p <= 7; p++) begin
          pos[p] = mq[p-1];
          e_hm[7-p] = mq[p-1];
          if (pos[p]) syn = syn ^ p;
        end
        e_syn = 3'(syn);
        e_err = (syn != 0);
`ifdef HAMMING_CORRECT_EN
        if (syn != 0) pos[syn] = ~pos[syn];
`endif
        e_data  = {pos[3], pos[5], pos[6], pos[7]};
        e_valid = 1'b1;
        if (e_err && e_cnt < CNT_MAX) e_cnt++;
        mq.delete();
      end
    end
  endtask

  task automatic step(input logic b, input logic a);
    chuan = b;
    align = a;
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else model_edge(b, a);
    check_all();
  endtask

  task automatic send_frame(input logic [6:0] hm, input logic with_align);
    for (int k = 6; k >= 0; k--) begin
      step(hm[k], (k == 6) ? with_align : 1'b0);
    end
  endtask

  function automatic logic [6:0] encode(input logic [3:0] d);
    bit pos[1:7];
    logic [6:0] hm;
    pos[3] = d[3];
    pos[5] = d[2];
    pos[6] = d[1];
    pos[7] = d[0];
    pos[1] = pos[3] ^ pos[5] ^ pos[7];
    pos[2] = pos[3] ^ pos[6] ^ pos[7];
    pos[4] = pos[5] ^ pos[6] ^ pos[7];
    for (int p = 1; p <= 7; p++) hm[7-p] = pos[p];
    return hm;
  endfunction

  initial begin
    logic [6:0] cw;
    int nflip;
    int npre;

    rst_n = 1'b0;
    chuan = 1'b0;
    align = 1'b0;
    model_reset();
    #12;
    check_all();

    // Release reset away from an edge; first edge is the SYNC cycle.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0);

    // Clean frames
    repeat (3) send_frame(7'b0110011, 1'b0);
    check("clean_data", 32'(data_out), 32'h0b);
    check("clean_valid_after_frame", 32'(valid), 32'd1);

    // Position 5 flipped
    repeat (3) send_frame(7'b0110111, 1'b0);
    check("err_syn", 32'(syndrome), 32'h5);
    check("err_cnt3", 32'(err_cnt), 32'd3);

    // Align mid-frame: partial frame dropped
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    send_frame(7'b0110011, 1'b1);
    check("realign_valid", 32'(valid), 32'd1);
    check("realign_hm", 32'(hm_in), 32'h33);

    // Align coincident with counter == 6
    for (int k = 0; k < 6; k++) step(1'(k & 1), 1'b0);
    send_frame(7'b0110011, 1'b1);
    check("align_at6_hm", 32'(hm_in), 32'h33);

    // Random frames, 0..2 flips, occasional realignment
    for (int i = 0; i < 200; i++) begin
      cw = encode(4'($urandom_range(0, 15)));
      nflip = $urandom_range(0, 2);
      for (int f = 0; f < nflip; f++) cw[$urandom_range(0, 6)] ^= 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        npre = $urandom_range(0, 6);
        for (int k = 0; k < npre; k++) step(1'($urandom_range(0, 1)), 1'b0);
        send_frame(cw, 1'b1);
      end else begin
        send_frame(cw, 1'b0);
      end
    end

    // Reset mid-frame: outputs clear without waiting for an edge
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    step(1'b1, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    send_frame(7'b0110011, 1'b0);
    check("post_reset_valid", 32'(valid), 32'd1);

    // Saturation
    repeat (300) send_frame(7'b0110111, 1'b0);
    check("err_cnt_sat", 32'(err_cnt), 32'(CNT_MAX));
    step(1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
